// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer: state encoding,
// wait counter width and the default memory timeout.
package pipeline_ctrl_pkg;

    localparam int STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_RUN      = 2'd0;
    localparam state_t S_MEM_WAIT = 2'd1;
    localparam state_t S_TRAP     = 2'd2;

    localparam int WAIT_W              = 8;
    localparam int MEM_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: Mealy freeze/flush/bubble
// controls, a memory-wait FSM with timeout trap, and stall/flush counters.
module pipeline_stall_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             bubble_id_exe,
    output logic             flush_if_id,
    output logic             freeze_back,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(MEM_TIMEOUT);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_error_q, mem_error_d;

    logic fpc_c, fifid_c, bub_c, flush_c, fback_c;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        mem_error_d = mem_error_q;
        fpc_c       = 1'b0;
        fifid_c     = 1'b0;
        bub_c       = 1'b0;
        flush_c     = 1'b0;
        fback_c     = 1'b0;

        case (state_q)
            S_RUN, S_MEM_WAIT: begin
                if (!mem_ready && (mem_req || state_q == S_MEM_WAIT)) begin
                    // Outstanding access: freeze everything, ignore EXE/ID requests.
                    fpc_c   = 1'b1;
                    fifid_c = 1'b1;
                    fback_c = 1'b1;
                    if (state_q == S_RUN) begin
                        state_d    = S_MEM_WAIT;
                        wait_cnt_d = 8'd1;
                    end else if (wait_cnt_q == TIMEOUT) begin
                        state_d     = S_TRAP;
                        mem_error_d = 1'b1;
                        wait_cnt_d  = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                    // A taken branch squashes the hazarding instruction, so it wins.
                    if (br_taken) begin
                        flush_c = 1'b1;
                        bub_c   = 1'b1;
                    end else if (hazard_detected) begin
                        fpc_c   = 1'b1;
                        fifid_c = 1'b1;
                        bub_c   = 1'b1;
                    end
                end
            end
            default: begin
                // TRAP and the unused encoding both hold the pipeline until reset.
                state_d     = S_TRAP;
                mem_error_d = 1'b1;
                fpc_c       = 1'b1;
                fifid_c     = 1'b1;
                fback_c     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RUN;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_error_q <= mem_error_d;
        end
    end

    // Controls are combinational in the inputs, so gate them with rst directly.
    assign freeze_pc     = fpc_c   & ~rst;
    assign freeze_if_id  = fifid_c & ~rst;
    assign bubble_id_exe = bub_c   & ~rst;
    assign flush_if_id   = flush_c & ~rst;
    assign freeze_back   = fback_c & ~rst;
    assign mem_error     = mem_error_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (freeze_pc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_if_id),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: one instance with a short timeout
// and wide counters, one with narrow counters for saturation.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic hazard_detected, br_taken, mem_req, mem_ready;

    logic        a_fpc, a_fifid, a_bub, a_flush, a_fback, a_mem_error;
    logic [15:0] a_stall, a_flush_cnt;
    logic        b_fpc, b_fifid, b_bub, b_flush, b_fback, b_mem_error;
    logic [2:0]  b_stall, b_flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Control vector order: {freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_back}
    logic [4:0] a_ctl, b_ctl;
    assign a_ctl = {a_fpc, a_fifid, a_bub, a_flush, a_fback};
    assign b_ctl = {b_fpc, b_fifid, b_bub, b_flush, b_fback};

    localparam logic [4:0] CTL_NONE   = 5'b00000;
    localparam logic [4:0] CTL_HAZARD = 5'b11100;
    localparam logic [4:0] CTL_BRANCH = 5'b00110;
    localparam logic [4:0] CTL_MEM    = 5'b11001;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut_a (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .br_taken        (br_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .freeze_pc       (a_fpc),
        .freeze_if_id    (a_fifid),
        .bubble_id_exe   (a_bub),
        .flush_if_id     (a_flush),
        .freeze_back     (a_fback),
        .mem_error       (a_mem_error),
        .stall_cycles    (a_stall),
        .flush_count     (a_flush_cnt)
    );

    pipeline_stall_ctrl #(.MEM_TIMEOUT(16), .CNT_W(3)) dut_b (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .br_taken        (br_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .freeze_pc       (b_fpc),
        .freeze_if_id    (b_fifid),
        .bubble_id_exe   (b_bub),
        .flush_if_id     (b_flush),
        .freeze_back     (b_fback),
        .mem_error       (b_mem_error),
        .stall_cycles    (b_stall),
        .flush_count     (b_flush_cnt)
    );

    task automatic set_in(input logic h, input logic b, input logic rq, input logic rd);
        hazard_detected = h;
        br_taken        = b;
        mem_req         = rq;
        mem_ready       = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0);
        rst = 1'b1;
        #2;
        n_checks++;
        if (a_ctl !== CTL_NONE || a_mem_error !== 1'b0 || a_stall !== 16'd0 || a_flush_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: ctl=%b err=%b stall=%0d flush=%0d, need ctl=00000 err=0 stall=0 flush=0",
                     a_ctl, a_mem_error, a_stall, a_flush_cnt);
        end
        // Inputs that would freeze in RUN must still leave the outputs low while rst=1.
        set_in(1, 0, 1, 0);
        #1;
        n_checks++;
        if (a_ctl !== CTL_NONE) begin
            n_fail++;
            $display("FAIL reset_gating: ctl=%b, need 00000", a_ctl);
        end
        tick();
        rst = 1'b0;
        set_in(0, 0, 0, 0);
        $display("test_reset done");
    endtask

    task automatic test_hazard();
        do_reset();
        set_in(1, 0, 0, 0);
        #1;
        n_checks++;
        if (a_ctl !== CTL_HAZARD) begin
            n_fail++;
            $display("FAIL hazard_cycle1: ctl=%b, need %b", a_ctl, CTL_HAZARD);
        end
        tick();
        n_checks++;
        if (a_ctl !== CTL_HAZARD) begin
            n_fail++;
            $display("FAIL hazard_cycle2: ctl=%b, need %b", a_ctl, CTL_HAZARD);
        end
        tick();
        set_in(0, 0, 0, 0);
        n_checks++;
        if (a_stall !== 16'd2 || a_flush_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL hazard_stall_count: stall=%0d flush=%0d, need stall=2 flush=0", a_stall, a_flush_cnt);
        end
        $display("test_hazard done");
    endtask

    task automatic test_branch_over_hazard();
        do_reset();
        set_in(1, 1, 0, 0);
        #1;
        n_checks++;
        if (a_ctl !== CTL_BRANCH) begin
            n_fail++;
            $display("FAIL branch_priority: ctl=%b, need %b", a_ctl, CTL_BRANCH);
        end
        tick();
        set_in(0, 0, 0, 0);
        n_checks++;
        if (a_flush_cnt !== 16'd1 || a_stall !== 16'd0) begin
            n_fail++;
            $display("FAIL branch_counts: flush=%0d stall=%0d, need flush=1 stall=0", a_flush_cnt, a_stall);
        end
        $display("test_branch_over_hazard done");
    endtask

    task automatic test_mem_hit();
        do_reset();
        // Access completing in the same cycle causes no freeze; the hazard still applies.
        set_in(1, 0, 1, 1);
        #1;
        n_checks++;
        if (a_ctl !== CTL_HAZARD) begin
            n_fail++;
            $display("FAIL mem_hit_fallthrough: ctl=%b, need %b", a_ctl, CTL_HAZARD);
        end
        tick();
        set_in(0, 0, 0, 0);
        $display("test_mem_hit done");
    endtask

    task automatic test_mem_wait();
        do_reset();
        set_in(0, 0, 1, 0);
        for (int i = 1; i <= 3; i++) begin
            #1;
            n_checks++;
            if (a_ctl !== CTL_MEM) begin
                n_fail++;
                $display("FAIL mem_wait_cycle%0d: ctl=%b, need %b", i, a_ctl, CTL_MEM);
            end
            tick();
        end
        set_in(0, 0, 1, 1);
        #1;
        n_checks++;
        if (a_ctl !== CTL_NONE) begin
            n_fail++;
            $display("FAIL mem_wait_release: ctl=%b, need 00000", a_ctl);
        end
        tick();
        n_checks++;
        if (a_stall !== 16'd3) begin
            n_fail++;
            $display("FAIL mem_wait_stall_count: stall=%0d, need 3", a_stall);
        end
        // Back in RUN, a hazard bubbles rather than holding the back end.
        set_in(1, 0, 0, 0);
        #1;
        n_checks++;
        if (a_ctl !== CTL_HAZARD) begin
            n_fail++;
            $display("FAIL mem_wait_back_in_run: ctl=%b, need %b", a_ctl, CTL_HAZARD);
        end
        set_in(0, 0, 0, 0);
        tick();
        $display("test_mem_wait done");
    endtask

    task automatic test_mem_wait_branch();
        do_reset();
        set_in(0, 1, 1, 0);
        for (int i = 1; i <= 3; i++) begin
            #1;
            n_checks++;
            if (a_ctl !== CTL_MEM) begin
                n_fail++;
                $display("FAIL wait_branch_cycle%0d: ctl=%b, need %b", i, a_ctl, CTL_MEM);
            end
            tick();
        end
        set_in(0, 1, 1, 1);
        #1;
        n_checks++;
        if (a_ctl !== CTL_BRANCH) begin
            n_fail++;
            $display("FAIL wait_branch_release: ctl=%b, need %b", a_ctl, CTL_BRANCH);
        end
        tick();
        set_in(0, 0, 0, 0);
        n_checks++;
        if (a_flush_cnt !== 16'd1 || a_stall !== 16'd3) begin
            n_fail++;
            $display("FAIL wait_branch_counts: flush=%0d stall=%0d, need flush=1 stall=3", a_flush_cnt, a_stall);
        end
        $display("test_mem_wait_branch done");
    endtask

    task automatic test_timeout_trap();
        do_reset();
        set_in(0, 0, 1, 0);
        for (int i = 1; i <= 4; i++) tick();
        n_checks++;
        if (a_mem_error !== 1'b0 || a_ctl !== CTL_MEM) begin
            n_fail++;
            $display("FAIL trap_not_yet: err=%b ctl=%b, need err=0 ctl=%b", a_mem_error, a_ctl, CTL_MEM);
        end
        tick();
        n_checks++;
        if (a_mem_error !== 1'b1) begin
            n_fail++;
            $display("FAIL trap_error_rise: err=%b, need 1", a_mem_error);
        end
        set_in(1, 1, 0, 1);
        #1;
        n_checks++;
        if (a_ctl !== CTL_MEM) begin
            n_fail++;
            $display("FAIL trap_hold: ctl=%b, need %b", a_ctl, CTL_MEM);
        end
        tick();
        n_checks++;
        if (a_ctl !== CTL_MEM || a_mem_error !== 1'b1 || a_stall !== 16'd6 || a_flush_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL trap_sticky: ctl=%b err=%b stall=%0d flush=%0d, need ctl=%b err=1 stall=6 flush=0",
                     a_ctl, a_mem_error, a_stall, a_flush_cnt, CTL_MEM);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (a_ctl !== CTL_NONE || a_mem_error !== 1'b0 || a_stall !== 16'd0 || a_flush_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL trap_reset_clear: ctl=%b err=%b stall=%0d flush=%0d, need all 0",
                     a_ctl, a_mem_error, a_stall, a_flush_cnt);
        end
        set_in(0, 0, 0, 0);
        tick();
        rst = 1'b0;
        set_in(1, 0, 0, 0);
        #1;
        n_checks++;
        if (a_ctl !== CTL_HAZARD) begin
            n_fail++;
            $display("FAIL trap_exit_to_run: ctl=%b, need %b", a_ctl, CTL_HAZARD);
        end
        set_in(0, 0, 0, 0);
        $display("test_timeout_trap done");
    endtask

    task automatic test_saturation_async_reset();
        do_reset();
        set_in(1, 0, 0, 0);
        for (int i = 1; i <= 10; i++) tick();
        n_checks++;
        if (b_stall !== 3'd7) begin
            n_fail++;
            $display("FAIL stall_saturate: stall=%0d, need 7", b_stall);
        end
        n_checks++;
        if (a_stall !== 16'd10) begin
            n_fail++;
            $display("FAIL stall_wide_count: stall=%0d, need 10", a_stall);
        end
        // Mid-cycle reset with the hazard still asserted: everything drops before the next edge.
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (b_ctl !== CTL_NONE || b_stall !== 3'd0 || b_flush_cnt !== 3'd0 || b_mem_error !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_b: ctl=%b stall=%0d flush=%0d err=%b, need all 0",
                     b_ctl, b_stall, b_flush_cnt, b_mem_error);
        end
        n_checks++;
        if (a_ctl !== CTL_NONE || a_stall !== 16'd0) begin
            n_fail++;
            $display("FAIL async_reset_a: ctl=%b stall=%0d, need ctl=00000 stall=0", a_ctl, a_stall);
        end
        set_in(0, 0, 0, 0);
        tick();
        rst = 1'b0;
        $display("test_saturation_async_reset done");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 0);
        test_reset();
        test_hazard();
        test_branch_over_hazard();
        test_mem_hit();
        test_mem_wait();
        test_mem_wait_branch();
        test_timeout_trap();
        test_saturation_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
